// File: rtl/hammu_axi4lite_master.sv
`default_nettype none
// ============================================================================
// hammu_axi4lite_master : single-outstanding AXI4-Lite master, one command
// in, one AXI write or read out, one response back; timeout recovers hangs.
// Revision: 1.0
// ============================================================================
module hammu_axi4lite_master #(
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int C_TIMEOUT          = 256
) (
    input  logic                            M_AXI_ACLK,
    input  logic                            M_AXI_ARESET,
    input  logic                            cmd_valid,
    output logic                            cmd_ready,
    input  logic                            cmd_write,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [C_M_AXI_DATA_WIDTH/8-1:0] cmd_wstrb,
    output logic                            rsp_valid,
    output logic                            rsp_write,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]                      rsp_resp,
    output logic                            rsp_timeout,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
    output logic                            M_AXI_AWVALID,
    input  logic                            M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
    output logic                            M_AXI_WVALID,
    input  logic                            M_AXI_WREADY,
    input  logic [1:0]                      M_AXI_BRESP,
    input  logic                            M_AXI_BVALID,
    output logic                            M_AXI_BREADY,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
    output logic                            M_AXI_ARVALID,
    input  logic                            M_AXI_ARREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
    input  logic [1:0]                      M_AXI_RRESP,
    input  logic                            M_AXI_RVALID,
    output logic                            M_AXI_RREADY
);

    localparam int SW         = C_M_AXI_DATA_WIDTH / 8;
    localparam int TW         = (C_TIMEOUT < 2) ? 2 : $clog2(C_TIMEOUT + 1) + 1;
    localparam int TMO_LAST_I = (C_TIMEOUT > 0) ? C_TIMEOUT - 1 : 0;
    localparam logic [TW-1:0] TMO_LAST = TMO_LAST_I[TW-1:0];

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WR_REQ  = 3'd1,
        S_WR_RESP = 3'd2,
        S_RD_REQ  = 3'd3,
        S_RD_RESP = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t                         state_q, state_d;
    logic                           live_q;
    logic [C_M_AXI_ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [C_M_AXI_DATA_WIDTH-1:0]  wdata_q, wdata_d;
    logic [SW-1:0]                  wstrb_q, wstrb_d;
    logic                           aw_done_q, aw_done_d;
    logic                           w_done_q, w_done_d;
    logic [TW-1:0]                  cnt_q, cnt_d;
    logic                           rsp_write_q, rsp_write_d;
    logic [C_M_AXI_DATA_WIDTH-1:0]  rsp_rdata_q, rsp_rdata_d;
    logic [1:0]                     rsp_resp_q, rsp_resp_d;
    logic                           rsp_timeout_q, rsp_timeout_d;
    logic                           busy, tmo_hit, abort;

    // live_q keeps cmd_ready low until the first edge after reset release
    assign cmd_ready     = live_q && (state_q == S_IDLE);
    assign rsp_valid     = (state_q == S_DONE);
    assign rsp_write     = rsp_write_q;
    assign rsp_rdata     = rsp_rdata_q;
    assign rsp_resp      = rsp_resp_q;
    assign rsp_timeout   = rsp_timeout_q;
    assign M_AXI_AWADDR  = addr_q;
    assign M_AXI_ARADDR  = addr_q;
    assign M_AXI_WDATA   = wdata_q;
    assign M_AXI_WSTRB   = wstrb_q;
    assign M_AXI_AWVALID = (state_q == S_WR_REQ) && !aw_done_q;
    assign M_AXI_WVALID  = (state_q == S_WR_REQ) && !w_done_q;
    assign M_AXI_BREADY  = (state_q == S_WR_RESP);
    assign M_AXI_ARVALID = (state_q == S_RD_REQ);
    assign M_AXI_RREADY  = (state_q == S_RD_RESP);

    assign busy    = (state_q != S_IDLE) && (state_q != S_DONE);
    // The final budgeted cycle still honours a handshake; abort only if none lands
    assign tmo_hit = (C_TIMEOUT != 0) && busy && (cnt_q >= TMO_LAST);

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        wstrb_d       = wstrb_q;
        aw_done_d     = aw_done_q;
        w_done_d      = w_done_q;
        cnt_d         = busy ? cnt_q + TW'(1) : cnt_q;
        rsp_write_d   = rsp_write_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_resp_d    = rsp_resp_q;
        rsp_timeout_d = rsp_timeout_q;
        abort         = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    addr_d    = cmd_addr;
                    wdata_d   = cmd_wdata;
                    wstrb_d   = cmd_wstrb;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    cnt_d     = '0;
                    state_d   = cmd_write ? S_WR_REQ : S_RD_REQ;
                end
            end
            S_WR_REQ: begin
                if (M_AXI_AWVALID && M_AXI_AWREADY) aw_done_d = 1'b1;
                if (M_AXI_WVALID && M_AXI_WREADY)   w_done_d  = 1'b1;
                if (aw_done_d && w_done_d) state_d = S_WR_RESP;
                else if (tmo_hit)          abort   = 1'b1;
            end
            S_WR_RESP: begin
                if (M_AXI_BVALID) begin
                    state_d       = S_DONE;
                    rsp_write_d   = 1'b1;
                    rsp_rdata_d   = '0;
                    rsp_resp_d    = M_AXI_BRESP;
                    rsp_timeout_d = 1'b0;
                end else if (tmo_hit) begin
                    abort = 1'b1;
                end
            end
            S_RD_REQ: begin
                if (M_AXI_ARREADY)  state_d = S_RD_RESP;
                else if (tmo_hit)   abort   = 1'b1;
            end
            S_RD_RESP: begin
                if (M_AXI_RVALID) begin
                    state_d       = S_DONE;
                    rsp_write_d   = 1'b0;
                    rsp_rdata_d   = M_AXI_RDATA;
                    rsp_resp_d    = M_AXI_RRESP;
                    rsp_timeout_d = 1'b0;
                end else if (tmo_hit) begin
                    abort = 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (abort) begin
            state_d       = S_DONE;
            rsp_write_d   = (state_q == S_WR_REQ) || (state_q == S_WR_RESP);
            rsp_rdata_d   = '0;
            rsp_resp_d    = 2'b10;
            rsp_timeout_d = 1'b1;
        end
    end

    always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
        if (M_AXI_ARESET) begin
            state_q       <= S_IDLE;
            live_q        <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
            aw_done_q     <= 1'b0;
            w_done_q      <= 1'b0;
            cnt_q         <= '0;
            rsp_write_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_resp_q    <= 2'b00;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            live_q        <= 1'b1;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            wstrb_q       <= wstrb_d;
            aw_done_q     <= aw_done_d;
            w_done_q      <= w_done_d;
            cnt_q         <= cnt_d;
            rsp_write_q   <= rsp_write_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_resp_q    <= rsp_resp_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hammu_axi4lite_master.sv
`default_nettype none
// ============================================================================
// tb_hammu_axi4lite_master : directed bench, slave handshakes driven per cycle.
// Revision: 1.0
// ============================================================================
module tb_hammu_axi4lite_master;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
    logic [31:0] cmd_addr = '0, cmd_wdata = '0;
    logic [3:0]  cmd_wstrb = '0;
    logic        rsp_valid, rsp_write, rsp_timeout;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [31:0] awaddr, wdata, araddr;
    logic [3:0]  wstrb;
    logic        awvalid, wvalid, bready, arvalid, rready;
    logic        awready = 1'b0, wready = 1'b0, bvalid = 1'b0, arready = 1'b0, rvalid = 1'b0;
    logic [1:0]  bresp = '0, rresp = '0;
    logic [31:0] rdata = '0;

    int n_tests = 0;
    int n_fail  = 0;

    hammu_axi4lite_master #(
        .C_M_AXI_ADDR_WIDTH (32),
        .C_M_AXI_DATA_WIDTH (32),
        .C_TIMEOUT          (16)
    ) dut (
        .M_AXI_ACLK    (clk),
        .M_AXI_ARESET  (rst),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_write     (cmd_write),
        .cmd_addr      (cmd_addr),
        .cmd_wdata     (cmd_wdata),
        .cmd_wstrb     (cmd_wstrb),
        .rsp_valid     (rsp_valid),
        .rsp_write     (rsp_write),
        .rsp_rdata     (rsp_rdata),
        .rsp_resp      (rsp_resp),
        .rsp_timeout   (rsp_timeout),
        .M_AXI_AWADDR  (awaddr),
        .M_AXI_AWVALID (awvalid),
        .M_AXI_AWREADY (awready),
        .M_AXI_WDATA   (wdata),
        .M_AXI_WSTRB   (wstrb),
        .M_AXI_WVALID  (wvalid),
        .M_AXI_WREADY  (wready),
        .M_AXI_BRESP   (bresp),
        .M_AXI_BVALID  (bvalid),
        .M_AXI_BREADY  (bready),
        .M_AXI_ARADDR  (araddr),
        .M_AXI_ARVALID (arvalid),
        .M_AXI_ARREADY (arready),
        .M_AXI_RDATA   (rdata),
        .M_AXI_RRESP   (rresp),
        .M_AXI_RVALID  (rvalid),
        .M_AXI_RREADY  (rready)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chkw(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Entered and left at posedge+1; AW/W ready arrive aw_dly/w_dly cycles late
    task automatic write_txn(input string tag, input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input int aw_dly, input int w_dly,
                             input int b_dly, input logic [1:0] resp);
        int aw_end, w_end, req_end;
        aw_end  = 1 + aw_dly;
        w_end   = 1 + w_dly;
        req_end = (aw_end > w_end) ? aw_end : w_end;
        cmd_valid = 1'b1; cmd_write = 1'b1;
        cmd_addr = addr; cmd_wdata = data; cmd_wstrb = strb;
        #1 chk1({tag, " accept"}, cmd_ready, 1'b1);
        step();
        cmd_valid = 1'b0; cmd_addr = ~addr; cmd_wdata = ~data; cmd_wstrb = ~strb;
        for (int k = 1; k <= req_end; k++) begin
            awready = (k == aw_end);
            wready  = (k == w_end);
            #1;
            chk1({tag, " awvalid"}, awvalid, k <= aw_end);
            chk1({tag, " wvalid"}, wvalid, k <= w_end);
            chk1({tag, " busy ready"}, cmd_ready, 1'b0);
            if (k <= aw_end) chkw({tag, " awaddr"}, awaddr, addr);
            if (k <= w_end) begin
                chkw({tag, " wdata"}, wdata, data);
                chkw({tag, " wstrb"}, 32'(wstrb), 32'(strb));
            end
            step();
        end
        awready = 1'b0; wready = 1'b0;
        for (int k = 0; k <= b_dly; k++) begin
            bvalid = (k == b_dly);
            bresp  = resp;
            #1;
            chk1({tag, " bready"}, bready, 1'b1);
            chk1({tag, " aw idle"}, awvalid, 1'b0);
            chk1({tag, " early rsp"}, rsp_valid, 1'b0);
            step();
        end
        bvalid = 1'b0; bresp = 2'b00;
        #1;
        chk1({tag, " rsp_valid"}, rsp_valid, 1'b1);
        chk1({tag, " rsp_write"}, rsp_write, 1'b1);
        chkw({tag, " rsp_resp"}, 32'(rsp_resp), 32'(resp));
        chk1({tag, " rsp_timeout"}, rsp_timeout, 1'b0);
        chkw({tag, " rsp_rdata"}, rsp_rdata, 32'h0);
        step();
        #1;
        chk1({tag, " rsp pulse"}, rsp_valid, 1'b0);
        chk1({tag, " ready again"}, cmd_ready, 1'b1);
    endtask

    task automatic read_txn(input string tag, input logic [31:0] addr, input int ar_dly,
                            input int r_dly, input logic [31:0] data, input logic [1:0] resp);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = addr;
        #1 chk1({tag, " accept"}, cmd_ready, 1'b1);
        step();
        cmd_valid = 1'b0; cmd_addr = ~addr;
        for (int k = 0; k <= ar_dly; k++) begin
            arready = (k == ar_dly);
            #1;
            chk1({tag, " arvalid"}, arvalid, 1'b1);
            chkw({tag, " araddr"}, araddr, addr);
            chk1({tag, " rready low"}, rready, 1'b0);
            step();
        end
        arready = 1'b0;
        for (int k = 0; k <= r_dly; k++) begin
            rvalid = (k == r_dly);
            rdata  = data;
            rresp  = resp;
            #1;
            chk1({tag, " rready"}, rready, 1'b1);
            chk1({tag, " ar idle"}, arvalid, 1'b0);
            step();
        end
        rvalid = 1'b0; rdata = 32'hdead_beef; rresp = 2'b00;
        #1;
        chk1({tag, " rsp_valid"}, rsp_valid, 1'b1);
        chk1({tag, " rsp_write"}, rsp_write, 1'b0);
        chkw({tag, " rsp_rdata"}, rsp_rdata, data);
        chkw({tag, " rsp_resp"}, 32'(rsp_resp), 32'(resp));
        chk1({tag, " rsp_timeout"}, rsp_timeout, 1'b0);
        step();
        #1;
        chk1({tag, " rsp pulse"}, rsp_valid, 1'b0);
        chk1({tag, " ready again"}, cmd_ready, 1'b1);
    endtask

    initial begin
        // Reset state
        #2;
        chk1("rst cmd_ready", cmd_ready, 1'b0);
        chk1("rst awvalid", awvalid, 1'b0);
        chk1("rst wvalid", wvalid, 1'b0);
        chk1("rst arvalid", arvalid, 1'b0);
        chk1("rst bready", bready, 1'b0);
        chk1("rst rready", rready, 1'b0);
        chk1("rst rsp_valid", rsp_valid, 1'b0);
        chkw("rst awaddr", awaddr, 32'h0);
        step();
        chk1("rst held ready", cmd_ready, 1'b0);
        rst = 1'b0;
        #1 chk1("post-rst ready before edge", cmd_ready, 1'b0);
        step();

        write_txn("wr zero-wait", 32'h7c80_0000, 32'h0000_0005, 4'hF, 0, 0, 0, 2'b00);
        write_txn("wr aw late", 32'h7c80_0010, 32'hA5A5_1234, 4'h3, 3, 0, 0, 2'b00);
        write_txn("wr w late", 32'h7c80_0014, 32'h0BAD_F00D, 4'hC, 0, 3, 0, 2'b00);
        read_txn("rd delayed", 32'h7c80_0004, 2, 1, 32'h0000_0094, 2'b00);
        write_txn("wr slverr", 32'h7c80_0020, 32'h1111_2222, 4'hF, 0, 0, 2, 2'b10);

        // Timeout: ARREADY never comes; a stray BVALID must be ignored
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h7c80_0008;
        #1 chk1("tmo accept", cmd_ready, 1'b1);
        step();
        cmd_valid = 1'b0;
        bvalid = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            #1;
            chk1("tmo arvalid held", arvalid, 1'b1);
            chk1("tmo no rsp", rsp_valid, 1'b0);
            step();
        end
        bvalid = 1'b0;
        #1;
        chk1("tmo arvalid dropped", arvalid, 1'b0);
        chk1("tmo rsp_valid", rsp_valid, 1'b1);
        chk1("tmo rsp_timeout", rsp_timeout, 1'b1);
        chkw("tmo rsp_resp", 32'(rsp_resp), 32'h2);
        chkw("tmo rsp_rdata", rsp_rdata, 32'h0);
        chk1("tmo rsp_write", rsp_write, 1'b0);
        step();
        #1;
        chk1("tmo ready again", cmd_ready, 1'b1);
        chk1("tmo fields held", rsp_timeout, 1'b1);
        write_txn("wr after tmo", 32'h7c80_0030, 32'hCAFE_0001, 4'h1, 0, 0, 0, 2'b00);

        // Reset while waiting in WR_RESP
        cmd_valid = 1'b1; cmd_write = 1'b1;
        cmd_addr = 32'h7c80_0040; cmd_wdata = 32'h5555_AAAA; cmd_wstrb = 4'hF;
        #1 chk1("mid-rst accept", cmd_ready, 1'b1);
        step();
        cmd_valid = 1'b0; awready = 1'b1; wready = 1'b1;
        #1;
        step();
        awready = 1'b0; wready = 1'b0;
        #1 chk1("mid-rst bready before", bready, 1'b1);
        rst = 1'b1;
        #1;
        chk1("mid-rst bready", bready, 1'b0);
        chk1("mid-rst cmd_ready", cmd_ready, 1'b0);
        chkw("mid-rst awaddr", awaddr, 32'h0);
        chkw("mid-rst wdata", wdata, 32'h0);
        chkw("mid-rst wstrb", 32'(wstrb), 32'h0);
        chk1("mid-rst rsp_valid", rsp_valid, 1'b0);
        chk1("mid-rst rsp_write", rsp_write, 1'b0);
        step();
        #1;
        chk1("mid-rst no rsp", rsp_valid, 1'b0);
        chk1("mid-rst ready held low", cmd_ready, 1'b0);
        rst = 1'b0;
        #1 chk1("release ready before edge", cmd_ready, 1'b0);
        step();
        write_txn("b2b write", 32'h7c80_0000, 32'h0000_0007, 4'hF, 0, 0, 0, 2'b00);
        read_txn("b2b read", 32'h7c80_0004, 0, 0, 32'h0000_0123, 2'b00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
